// File: rtl/dkongjr_obj_dma.sv
// Sprite-attribute DMA master: copies the CPU sprite table from work RAM into object RAM over the Z80 bus.
// Optional build macro OBJ_DMA_VBLANK_GATE_EN holds an accepted start in WAIT until vertical blank.
module dkongjr_obj_dma #(
  parameter int unsigned LEN      = 384,
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter logic [9:0]  DST_BASE = 10'h000
) (
  input  logic        CLK_12M,
  input  logic        RST_4L,
  input  logic        I_START,
  input  logic        I_VBLKn,
  input  logic        I_BUSAKn,
  input  logic [7:0]  I_SRC_DB,
  output logic        O_BUSRQn,
  output logic [15:0] O_SRC_AB,
  output logic        O_SRC_RDn,
  output logic [9:0]  O_OBJ_AB,
  output logic [7:0]  O_OBJ_DB,
  output logic        O_OBJ_WRn,
  output logic        O_OBJ_RQn,
  output logic        O_BUSY,
  output logic        O_DONE
);

  localparam int unsigned SRC_W = 16;
  localparam int unsigned DST_W = 10;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned DAT_W = 8;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD_A = 3'd2,
    RD_D = 3'd3,
    WR   = 3'd4,
    REL  = 3'd5
`ifdef OBJ_DMA_VBLANK_GATE_EN
    , WAIT = 3'd6
`endif
  } state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic               start_edge;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [DST_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SRC_W-1:0]   src_ab_d;
  logic [DST_W-1:0]   obj_ab_d;
  logic [DAT_W-1:0]   obj_db_d;
  logic               busrq_n_d, src_rd_n_d, obj_wr_n_d, obj_rq_n_d, busy_d, done_d;

`ifndef OBJ_DMA_VBLANK_GATE_EN
  logic unused_vblkn;
  assign unused_vblkn = I_VBLKn;
`endif

  // State, counters and every output are flopped here; outputs are decoded from the next state.
  always_ff @(posedge CLK_12M or negedge RST_4L) begin
    if (!RST_4L) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      O_BUSRQn  <= 1'b1;
      O_SRC_AB  <= '0;
      O_SRC_RDn <= 1'b1;
      O_OBJ_AB  <= '0;
      O_OBJ_DB  <= '0;
      O_OBJ_WRn <= 1'b1;
      O_OBJ_RQn <= 1'b1;
      O_BUSY    <= 1'b0;
      O_DONE    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= I_START;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      O_BUSRQn  <= busrq_n_d;
      O_SRC_AB  <= src_ab_d;
      O_SRC_RDn <= src_rd_n_d;
      O_OBJ_AB  <= obj_ab_d;
      O_OBJ_DB  <= obj_db_d;
      O_OBJ_WRn <= obj_wr_n_d;
      O_OBJ_RQn <= obj_rq_n_d;
      O_BUSY    <= busy_d;
      O_DONE    <= done_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    src_ab_d   = O_SRC_AB;
    obj_ab_d   = O_OBJ_AB;
    obj_db_d   = O_OBJ_DB;
    done_d     = 1'b0;
    start_edge = I_START & ~start_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          if (LEN_C == '0) begin
            done_d = 1'b1;
          end else begin
            src_d = SRC_BASE;
            dst_d = DST_BASE;
            cnt_d = LEN_C;
`ifdef OBJ_DMA_VBLANK_GATE_EN
            state_d = WAIT;
`else
            state_d = REQ;
`endif
          end
        end
      end
`ifdef OBJ_DMA_VBLANK_GATE_EN
      WAIT: if (!I_VBLKn) state_d = REQ;
`endif
      REQ:  if (!I_BUSAKn) state_d = RD_A;
      RD_A: state_d = I_BUSAKn ? REQ : RD_D;
      RD_D: begin
        // Losing the bus here abandons the read; counters stay put so the byte is fetched again.
        if (I_BUSAKn) begin
          state_d = REQ;
        end else begin
          state_d  = WR;
          obj_ab_d = dst_q;
          obj_db_d = I_SRC_DB;
        end
      end
      WR: begin
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 10'd1;
        cnt_d   = cnt_q - 10'd1;
        state_d = (cnt_q == CNT_W'(1)) ? REL : RD_A;
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == RD_A) src_ab_d = src_d;

    busrq_n_d  = !(state_d inside {REQ, RD_A, RD_D, WR});
    src_rd_n_d = !(state_d inside {RD_A, RD_D});
    obj_wr_n_d = (state_d != WR);
    obj_rq_n_d = (state_d != WR);
    busy_d     = (state_d != IDLE);
    done_d     = done_d | (state_d == REL);
  end

endmodule

// File: doc/dkongjr_obj_dma.md
# dkongjr_obj_dma

Sprite-attribute DMA master that copies the CPU's sprite table from work RAM into object RAM, the write side of the object-RAM interface the sprite engine scans each line. A CPU strobe starts a transfer. The block then requests the Z80 bus, waits for acknowledge, and moves a fixed number of bytes with one read and one object-RAM write per byte. When the count is exhausted it releases the bus.

## Interface
Parameters:
- `LEN`, default 384: bytes per transfer (0..1023); 0 means no transfer.
- `SRC_BASE`, default 16'h6900: first source address.
- `DST_BASE`, default 10'h000: first object-RAM address.

Ports:
- `CLK_12M` in 1: block clock; all state changes on the rising edge.
- `RST_4L` in 1: reset, asynchronous, active-low; clock CLK_12M.
- `I_START` in 1: start request, level sampled each clock; rising edge detected internally.
- `I_VBLKn` in 1: vertical blank, active-low. Used only under the configuration macro.
- `I_BUSAKn` in 1: Z80 bus acknowledge, active-low.
- `I_SRC_DB` in 8: source read data, valid during `RD_D`.
- `O_BUSRQn` out 1: bus request, active-low.
- `O_SRC_AB` out 16: source address.
- `O_SRC_RDn` out 1: source read strobe, active-low.
- `O_OBJ_AB` out 10: object-RAM address.
- `O_OBJ_DB` out 8: object-RAM write data.
- `O_OBJ_WRn` out 1: object-RAM write strobe, active-low.
- `O_OBJ_RQn` out 1: object-RAM select, active-low.
- `O_BUSY` out 1: high from start acceptance until return to `IDLE`.
- `O_DONE` out 1: one-clock pulse at completion.

## Operation
- States:
  - `IDLE`: waiting for a start.
  - `WAIT`: gated start pending; exists only under the macro.
  - `REQ`: bus requested, waiting for acknowledge.
  - `RD_A`: source address driven, read strobe low.
  - `RD_D`: read strobe still low; `I_SRC_DB` is captured into the data register at the end of this clock.
  - `WR`: object-RAM write cycle.
  - `REL`: bus release.
- `IDLE`:
  - Start rising edge with LEN>0: load the source counter with SRC_BASE, the destination counter with DST_BASE and the byte counter with LEN, then go to `REQ`.
  - Start rising edge with LEN=0: pulse `O_DONE` and stay in `IDLE`; `O_BUSRQn` is never asserted.
- `REQ`: `O_BUSRQn`=0. When `I_BUSAKn` is sampled 0, go to `RD_A`.
- `RD_A`: `O_SRC_AB`=source counter, `O_SRC_RDn`=0, then go to `RD_D`.
- `RD_D`: `O_SRC_RDn`=0; latch `I_SRC_DB`, then go to `WR`.
- `WR`:
  - `O_OBJ_AB`=destination counter, `O_OBJ_DB`=latched data, `O_OBJ_RQn`=0 and `O_OBJ_WRn`=0 for exactly one clock.
  - Increment source, increment destination, decrement byte count.
  - If the count reaches 0, go to `REL`; otherwise go to `RD_A`.
- `REL`: `O_BUSRQn`=1 and `O_DONE`=1 for one clock, then go to `IDLE`.
- Arithmetic and wrap-around:
  - Source counter is 16-bit and wraps FFFF→0000.
  - Destination counter is 10-bit and wraps 3FF→000.
  - Byte counter is 10-bit.
- Bus lost mid-transfer: `I_BUSAKn` sampled 1 in `RD_A` or `RD_D` means abandon the current read and go to `REQ`.
  - `O_SRC_RDn` goes to 1.
  - Counters are unchanged, so the byte is re-read after re-grant.
  - A `WR` in progress always completes.
- Start while busy: ignored, with no queuing.
- Reset at any time: immediate return to `IDLE` with the reset output values; a partial transfer is abandoned.
- Output reset values:
  - `O_BUSRQn`, `O_SRC_RDn`, `O_OBJ_WRn`, `O_OBJ_RQn` = 1.
  - Address and data outputs = 0.
  - `O_BUSY`, `O_DONE` = 0.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Timing
- Start edge at clock n means `O_BUSRQn` low from clock n+1.
- Grant sampled at clock g means `RD_A` at g+1, `RD_D` at g+2, `WR` at g+3.
- Each byte takes 3 clocks; `O_OBJ_WRn` is low 1 clock in every 3.
- Total time from the grant sample to `O_BUSRQn` high is 3·LEN+1 clocks: 1153 clocks for LEN=384.
- `O_DONE` is asserted in the same clock that `O_BUSRQn` returns high.
- `O_BUSY` falls one clock after `O_DONE`, on return to `IDLE`.
- `O_OBJ_AB` and `O_OBJ_DB` are stable throughout the `WR` clock; `O_OBJ_WRn` rises at the end of it.

## Configuration
- `OBJ_DMA_VBLANK_GATE_EN`
  - Defined: an accepted start enters `WAIT` with `O_BUSY`=1, and the block moves to `REQ` only on a clock where `I_VBLKn`=0. If vblank is already active at the start edge, the block enters `REQ` one clock later than the ungated case.
  - Undefined: `WAIT` does not exist, `I_VBLKn` is ignored, and a start goes directly to `REQ`.

## Test plan
- Default transfer:
  - Stimulus: defaults; source memory holds byte k = k[7:0] ^ 8'h5A; start pulse; `I_BUSAKn` tied 0 two clocks after request.
  - Required: 384 writes, object RAM address k = k[7:0]^5A, `O_OBJ_WRn` low every 3rd clock, single `O_DONE` pulse.
  - Required: `O_BUSRQn` low for 1153 clocks after the grant sample.
- Wrap-around:
  - Stimulus: LEN=4, DST_BASE=3FE, SRC_BASE=FFFE.
  - Required: writes to object-RAM addresses 3FE, 3FF, 000, 001 with data read from source addresses FFFE, FFFF, 0000, 0001.
- LEN=0:
  - Stimulus: start with LEN=0.
  - Required: `O_DONE` pulse one clock after the edge; `O_BUSRQn` stays 1 and no strobes occur.
- Bus withdrawn:
  - Stimulus: LEN=8; `I_BUSAKn` raised in `RD_D` of byte 3 for 5 clocks.
  - Required: `O_SRC_RDn` returns to 1 and byte 3 is re-read after re-grant; exactly 8 writes occur with no duplicates.
- Reset and busy start:
  - Stimulus: a second start during a transfer.
  - Required: the second start is ignored.
  - Stimulus: assert `RST_4L` after 100 bytes.
  - Required: all outputs at reset values the same clock; no further writes.
- Macro gating:
  - Stimulus: with `OBJ_DMA_VBLANK_GATE_EN`, start while `I_VBLKn`=1, then drop `I_VBLKn` 20 clocks later.
  - Required: `O_BUSY`=1 immediately; `O_BUSRQn` falls the clock after `I_VBLKn` is sampled 0.
